// File: rtl/abft_pkg.sv
// Shared ABFT constants, FSM states and flattened-vector index helper.
// Imported by the checksum encoder and the downstream checker.
package abft_pkg;

    localparam int ABFT_N  = 4;
    localparam int ABFT_DW = 8;
    localparam int ABFT_CW = ABFT_DW + $clog2(ABFT_N);
    localparam int ABFT_GW = ABFT_DW + 2 * $clog2(ABFT_N);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_EMIT
    } abft_state_e;

    // LSB position of entry idx in a flattened vector of w-bit fields.
    function automatic int unsigned abft_lsb(
        input int unsigned idx,
        input int unsigned w
    );
        return idx * w;
    endfunction

endpackage

// File: rtl/abft_sum_acc.sv
// Single W-bit accumulator: zero-extended DW-bit add, synchronous clear.
// Ports: clk, rst (async high), clr_i, add_i, data_i[DW], sum_o[W].
module abft_sum_acc #(
    parameter int W  = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          add_i,
    input  logic [DW-1:0] data_i,
    output logic [W-1:0]  sum_o
);

    logic [W-1:0] sum_q;
    logic [W-1:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (add_i) begin
            sum_d = sum_q + W'(data_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/abft_checksum_gen.sv
// ABFT encoder: accumulates row, column and grand checksums of an N x N
// row-major matrix and holds the set until the consumer takes it.
// Ports: clk, rst (async high), clr (sync abort), in_valid/in_ready/in_data,
//   out_valid/out_ready, row_sum/col_sum [N*CW], grand_sum [GW], busy.
// Optional: define ABFT_FAULT_INJECT_EN to add inj_en/inj_sel, which flip
//   bit 0 of one selected row/column checksum while the set is presented.
module abft_checksum_gen
    import abft_pkg::*;
#(
    parameter  int N  = ABFT_N,
    parameter  int DW = ABFT_DW,
    localparam int CW = DW + $clog2(N),
    localparam int GW = DW + 2 * $clog2(N),
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int SW = $clog2(2 * N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*CW-1:0] row_sum,
    output logic [N*CW-1:0] col_sum,
    output logic [GW-1:0]   grand_sum,
    output logic            busy
`ifdef ABFT_FAULT_INJECT_EN
    ,
    input  logic            inj_en,
    input  logic [SW-1:0]   inj_sel
`endif
);

    abft_state_e     state_q;
    abft_state_e     state_d;
    logic [IW-1:0]   r_q;
    logic [IW-1:0]   r_d;
    logic [IW-1:0]   c_q;
    logic [IW-1:0]   c_d;
    logic [GW-1:0]   grand_q;
    logic [GW-1:0]   grand_d;
    logic [N*CW-1:0] row_vec;
    logic [N*CW-1:0] col_vec;
    logic            fire;
    logic            take;
    logic            last;
    logic            acc_clr;

    assign in_ready = (state_q != ST_EMIT);
    // clr wins over a same-cycle element even though in_ready may be 1.
    assign fire     = in_valid & in_ready & ~clr;
    assign take     = (state_q == ST_EMIT) & out_ready;
    assign acc_clr  = clr | take;
    assign last     = (r_q == IW'(N - 1)) && (c_q == IW'(N - 1));

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        grand_d = grand_q;
        unique case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (fire) begin
                    grand_d = grand_q + GW'(in_data);
                    state_d = last ? ST_EMIT : ST_ACCUM;
                    if (c_q == IW'(N - 1)) begin
                        c_d = '0;
                        r_d = last ? '0 : r_q + 1'b1;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    r_d     = '0;
                    c_d     = '0;
                    grand_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clr) begin
            state_d = ST_IDLE;
            r_d     = '0;
            c_d     = '0;
            grand_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            grand_q <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            grand_q <= grand_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_acc
        localparam int LSB = abft_lsb(i, CW);

        abft_sum_acc #(
            .W  (CW),
            .DW (DW)
        ) u_row (
            .clk    (clk),
            .rst    (rst),
            .clr_i  (acc_clr),
            .add_i  (fire && (r_q == IW'(i))),
            .data_i (in_data),
            .sum_o  (row_vec[LSB +: CW])
        );

        abft_sum_acc #(
            .W  (CW),
            .DW (DW)
        ) u_col (
            .clk    (clk),
            .rst    (rst),
            .clr_i  (acc_clr),
            .add_i  (fire && (c_q == IW'(i))),
            .data_i (in_data),
            .sum_o  (col_vec[LSB +: CW])
        );
    end

    assign out_valid = (state_q == ST_EMIT);
    assign busy      = (state_q != ST_IDLE);
    assign grand_sum = grand_q;

`ifdef ABFT_FAULT_INJECT_EN
    localparam logic [N*CW-1:0] BIT0 = (N*CW)'(1);

    logic [N*CW-1:0] row_flip;
    logic [N*CW-1:0] col_flip;

    // Output-side corruption only; the accumulators keep the true sums.
    always_comb begin
        row_flip = '0;
        col_flip = '0;
        if ((state_q == ST_EMIT) && inj_en) begin
            if (int'(inj_sel) < N) begin
                row_flip = BIT0 << abft_lsb(int'(inj_sel), CW);
            end else begin
                col_flip = BIT0 << abft_lsb(int'(inj_sel) - N, CW);
            end
        end
    end

    assign row_sum = row_vec ^ row_flip;
    assign col_sum = col_vec ^ col_flip;
`else
    assign row_sum = row_vec;
    assign col_sum = col_vec;
`endif

endmodule

// File: tb/tb_abft_checksum_gen.sv
// Self-checking bench for abft_checksum_gen: directed scenarios plus
// random frames compared against a plain-arithmetic checksum model.
module tb_abft_checksum_gen;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 10;
    localparam int GW = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic            clr;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [N*CW-1:0] row_sum;
    logic [N*CW-1:0] col_sum;
    logic [GW-1:0]   grand_sum;
    logic            busy;
`ifdef ABFT_FAULT_INJECT_EN
    logic            inj_en;
    logic [2:0]      inj_sel;
`endif

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0]   mat [N*N];
    logic [N*CW-1:0] er;
    logic [N*CW-1:0] ec;
    logic [GW-1:0]   eg;
    logic [N*CW-1:0] snap_r;

    always #5 clk = ~clk;

    abft_checksum_gen dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .row_sum   (row_sum),
        .col_sum   (col_sum),
        .grand_sum (grand_sum),
        .busy      (busy)
`ifdef ABFT_FAULT_INJECT_EN
        ,
        .inj_en    (inj_en),
        .inj_sel   (inj_sel)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: sums straight from the matrix definition.
    task automatic model();
        int rs [N];
        int cs [N];
        int g;
        int v;
        g = 0;
        for (int i = 0; i < N; i++) begin
            rs[i] = 0;
            cs[i] = 0;
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                v = int'(mat[i*N+j]);
                rs[i] += v;
                cs[j] += v;
                g += v;
            end
        end
        er = '0;
        ec = '0;
        for (int i = 0; i < N; i++) begin
            er[i*CW +: CW] = rs[i][CW-1:0];
            ec[i*CW +: CW] = cs[i][CW-1:0];
        end
        eg = g[GW-1:0];
    endtask

    task automatic send_frame(input int gap_pct);
        for (int k = 0; k < N*N; k++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = mat[k];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = DW'($urandom);
    endtask

    task automatic chk_sums(input string tag);
        model();
        chk({tag, "_row"}, 64'(row_sum), 64'(er));
        chk({tag, "_col"}, 64'(col_sum), 64'(ec));
        chk({tag, "_grand"}, 64'(grand_sum), 64'(eg));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ovalid"}, 64'(out_valid), 64'd0);
        chk({tag, "_iready"}, 64'(in_ready), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_row0"}, 64'(row_sum), 64'd0);
        chk({tag, "_col0"}, 64'(col_sum), 64'd0);
        chk({tag, "_grand0"}, 64'(grand_sum), 64'd0);
    endtask

    task automatic seq_fill();
        for (int k = 0; k < N*N; k++) mat[k] = DW'(k + 1);
    endtask

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef ABFT_FAULT_INJECT_EN
        inj_en    = 1'b0;
        inj_sel   = '0;
`endif
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("post_reset");

        // Frame 1..16, consumer always ready
        seq_fill();
        send_frame(0);
        chk("s1_ovalid", 64'(out_valid), 64'd1);
        chk("s1_iready", 64'(in_ready), 64'd0);
        chk("s1_busy", 64'(busy), 64'd1);
        chk_sums("s1");
        chk("s1_grand_k", 64'(grand_sum), 64'd136);
        chk("s1_row3_k", 64'(row_sum[3*CW +: CW]), 64'd58);
        chk("s1_col0_k", 64'(col_sum[0 +: CW]), 64'd28);
        @(negedge clk);
        chk_idle("s1_after");

        // All 255: maximum sums, no wrap
        for (int k = 0; k < N*N; k++) mat[k] = 8'hFF;
        send_frame(0);
        chk_sums("s2");
        chk("s2_row2_k", 64'(row_sum[2*CW +: CW]), 64'd1020);
        chk("s2_grand_k", 64'(grand_sum), 64'd4080);
        @(negedge clk);

        // Consumer stalls 5 cycles, in_valid pulses must be ignored
        seq_fill();
        out_ready = 1'b0;
        send_frame(0);
        chk_sums("s3_enter");
        for (int t = 0; t < 5; t++) begin
            in_valid = 1'($urandom);
            in_data  = DW'($urandom);
            @(negedge clk);
            chk("s3_hold_ovalid", 64'(out_valid), 64'd1);
            chk("s3_hold_iready", 64'(in_ready), 64'd0);
            chk_sums("s3_hold");
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk_idle("s3_after");

        // Partial frame aborted by clr with a valid element present
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            in_data  = 8'd9;
            @(negedge clk);
        end
        chk("s4_busy_mid", 64'(busy), 64'd1);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd9;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        chk_idle("s4_clr");
        for (int k = 0; k < N*N; k++) mat[k] = 8'd1;
        send_frame(0);
        chk_sums("s4");
        chk("s4_grand_k", 64'(grand_sum), 64'd16);
        @(negedge clk);

        // Asynchronous reset mid-frame
        seq_fill();
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = mat[k];
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_idle("s5_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_frame(0);
        chk("s5_ovalid", 64'(out_valid), 64'd1);
        chk_sums("s5");
        @(negedge clk);

        // Random frames with input gaps and consumer back-pressure
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < N*N; k++) begin
                mat[k] = (f == 0) ? 8'hFF : DW'($urandom);
            end
            out_ready = 1'b0;
            send_frame(30);
            chk("rnd_ovalid", 64'(out_valid), 64'd1);
            chk_sums("rnd");
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk_sums("rnd_hold");
            end
            out_ready = 1'b1;
            @(negedge clk);
            chk("rnd_done", 64'(out_valid), 64'd0);
        end

`ifdef ABFT_FAULT_INJECT_EN
        seq_fill();
        out_ready = 1'b0;
        send_frame(0);
        inj_en  = 1'b1;
        inj_sel = 3'd5;
        #1;
        model();
        chk("inj_col", 64'(col_sum), 64'(ec ^ (40'd1 << CW)));
        chk("inj_col1", 64'(col_sum[CW +: CW]), 64'd33);
        chk("inj_row", 64'(row_sum), 64'(er));
        chk("inj_grand", 64'(grand_sum), 64'(eg));
        inj_en = 1'b0;
        #1;
        chk("noinj_col1", 64'(col_sum[CW +: CW]), 64'd32);
        out_ready = 1'b1;
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/abft_checksum_gen.md
Name: abft_checksum_gen

Overview:
- Encoder side of the ABFT datapath: streams in one N x N operand matrix, row-major, one element per handshake.
- Produces the row checksums, column checksums and grand checksum that the downstream ABFT checker consumes.
- Sits between the operand source and the checker/multiplier, so checksums are generated from data the checker never sees.
- Holds each completed checksum set until the consumer takes it.

Parameters:
- N, 4, matrix dimension (N x N elements per frame)
- DW, 8, element width in bits
- CW, DW+$clog2(N), width of each row/column checksum (derived, not overridable)
- GW, DW+2*$clog2(N), width of the grand checksum (derived)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- clr  in  1  synchronous frame abort/clear
- in_valid  in  1  element valid
- in_ready  out  1  block can accept an element
- in_data  in  DW  element, unsigned
- out_valid  out  1  checksum set valid
- out_ready  in  1  consumer accepts checksum set
- row_sum  out  N*CW  row checksums, row i at bits [i*CW +: CW]
- col_sum  out  N*CW  column checksums, column j at bits [j*CW +: CW]
- grand_sum  out  GW  sum of all elements
- busy  out  1  frame in progress (ACCUM or EMIT)

Behaviour:
- Reset (rst high, asynchronous):
  - state = IDLE; row/col counters = 0; all accumulators = 0.
  - in_ready=1, out_valid=0, busy=0, row_sum/col_sum/grand_sum=0.
- States:
  - IDLE: in_ready=1. The first accepted element goes to ACCUM.
  - ACCUM: in_ready=1. Each in_valid&in_ready adds in_data to row_acc[r], col_acc[c] and grand_acc.
    - Counter c increments; on c==N-1, c wraps to 0 and r increments.
    - On the N*N-th handshake (r==N-1, c==N-1), move to EMIT.
  - EMIT: in_ready=0, out_valid=1. Outputs are the accumulators, stable while out_ready is low.
    - On out_valid&out_ready: clear accumulators and counters, go to IDLE.
    - in_ready returns to 1 the following cycle.
- Latency: out_valid rises the cycle after the final element's handshake. Accepting a new frame takes 1 idle cycle minimum after the out handshake.
- Accumulators are cleared when leaving EMIT. The first element of a frame is therefore added to zero. No separate load path.
- Width rules:
  - Zero-extend in_data before each add.
  - CW and GW cannot overflow for any input: max row sum N*(2^DW-1), max grand sum N*N*(2^DW-1).
- busy=1 in ACCUM and EMIT.
- clr (sync) has priority over all handshakes in the same cycle:
  - Clears accumulators and counters, drops out_valid, goes to IDLE.
  - The element presented that cycle is not accepted, even though in_ready may read 1.
- in_valid while in EMIT is ignored and not consumed.
- Reset mid-frame: immediate return to reset values. The partial frame is discarded.
- Outputs are registered. No combinational path from in_data to the output ports.

Optional Feature:
- ABFT_FAULT_INJECT_EN
  - When defined, adds inputs inj_en (1) and inj_sel (log2(2N)).
  - While in EMIT with inj_en=1, bit 0 of the selected checksum is inverted at the output: sel < N selects row_sum[sel], otherwise col_sum[sel-N].
  - Accumulators are not altered.
  - Used to prove the downstream checker flags errors.
- When undefined, the ports and logic are absent and outputs are always true sums.

Decomposition:
- Shared package abft_pkg:
  - N, DW, CW, GW constants.
  - State enum IDLE/ACCUM/EMIT.
  - Index helper for flattened checksum vectors.
  - The downstream checker uses the same package.
- One sub-module is natural: abft_sum_acc, a single CW-bit accumulator with add/clear enables. Instantiate it N times for rows and N times for columns.
- grand_acc stays inline.

Test Plan:
- Elements 1..16 row-major, out_ready=1 -> row_sum={10,26,42,58}, col_sum={28,32,36,40}, grand_sum=136. out_valid high exactly 1 cycle, 1 cycle after the 16th handshake.
- All elements 255 -> every row_sum/col_sum=1020, grand_sum=4080, no wrap.
- Frame 1..16 with out_ready held low 5 cycles -> outputs stable and in_ready=0 throughout. in_valid pulses are ignored. Handshake on cycle 6; in_ready=1 next cycle.
- 7 elements of 9, then clr asserted with in_valid=1, then a frame of all 1s -> row/col sums all 4, grand_sum=16. The clr-cycle element is not counted.
- rst asserted asynchronously mid-frame after 10 elements -> all outputs 0 immediately. Next full frame 1..16 gives the same results as the first scenario.
- ABFT_FAULT_INJECT_EN defined, frame 1..16, inj_en=1, inj_sel=5 -> col_sum[1]=33, all other sums unchanged. inj_en=0 -> col_sum[1]=32.
